sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-port arbiter in front of the SRAM controller. Requester 0 is the MEM-stage data port; requester 1 is a secondary master such as the debug/loader port. Each requester presents a 32-bit word read or write with a level handshake. The arbiter grants one requester at a time, sequences the controller's enable/ready protocol, returns read data, and flags accesses that never complete.

## Interface
- `RR`, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, port 0 always wins.
- `TIMEOUT`, default 255: maximum cycles spent in ISSUE+WAIT before the access is aborted. Range 2..255.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `pN_rd_en`, `pN_wr_en`  in  1 each (N = 0, 1)  request level; held until `pN_ready`
- `pN_address`  in  32  byte address; held stable while requesting
- `pN_write_data`  in  32  write word; held stable while requesting
- `pN_ready`  out  1  one-cycle completion pulse
- `pN_read_data`  out  32  registered read word
- `pN_stall`  out  1  request pending and not completing this cycle
- `pN_error`  out  1  one-cycle pulse with `pN_ready` on timeout abort
- `mem_rd_en`, `mem_wr_en`  out  1 each  to the controller
- `mem_address`, `mem_write_data`  out  32 each  to the controller
- `mem_ready`  in  1  controller ready: low while busy, high when idle or finishing
- `mem_read_data`  in  32  controller read word; valid in the cycle `mem_ready` returns high

## Operation
- **States:** IDLE, ISSUE, WAIT, DONE. Register `owner` (1 bit), register `last` (1 bit), and an 8-bit timeout counter.
- **IDLE**
  - A port requests when `rd_en` or `wr_en` is set. If both bits are set on one port, the access is treated as a write.
  - RR=1: with both ports requesting, grant `!last`. RR=0: port 0 wins.
  - On grant: latch owner, address, write data and direction into the `mem_*` registers, clear the counter, go to ISSUE.
- **ISSUE**
  - Drive `mem_rd_en` or `mem_wr_en`.
  - Go to WAIT when `mem_ready` = 0 is seen.
- **WAIT**
  - Keep the enable asserted.
  - When `mem_ready` = 1: capture `mem_read_data` into `p<owner>_read_data` (reads only), go to DONE.
- **DONE**
  - Deassert both enables so the controller cannot re-sample the request.
  - Pulse `p<owner>_ready`, set `last` = owner, go to IDLE.
- **Timeout**
  - The counter increments every cycle in ISSUE or WAIT.
  - Reaching `TIMEOUT` forces DONE with `p<owner>_error` = 1.
  - Read data is not updated on a timeout.
- **Stall:** `pN_stall` = (`pN_rd_en` | `pN_wr_en`) & ~`pN_ready`. It is combinational, for pipeline freeze.
- **Holding rules**
  - `pN_read_data` holds its value until that port's next successful read.
  - Writes never modify it.
- A requester dropping its request mid-access does not abort the access. It still completes and pulses `pN_ready`.

## Timing
- **Reset:** state IDLE; `last` = 1, so port 0 wins the first tie; counter 0. `mem_rd_en`, `mem_wr_en`, `pN_ready` and `pN_error` are 0. `mem_address`, `mem_write_data` and `pN_read_data` are 0.
- **Cycle sequence:** request seen in IDLE at edge k → enable high from k+1 → `mem_ready` low → `mem_ready` high at edge j → `pN_ready` high in cycle j+1 → back in IDLE at j+2.
- **Back-to-back:** the earliest new grant is sampled in that IDLE cycle (j+2), so there is one cycle of overhead per access.
- **Request retirement:** a requester must deassert or change its request in the cycle after `pN_ready`. A request still held in IDLE is treated as a new access.
- **Simultaneous events:** a new request arriving while busy waits in IDLE arbitration and is never queued. A port losing arbitration keeps `pN_stall` high.
- **Reset mid-access:** return to IDLE next edge with enables low. The controller shares `rst`; no `pN_ready` is issued for the aborted access.

## Test plan
- **Single read:** p0 reads 0x0000_0100; controller model returns 0xDEAD_BEEF after 6 busy cycles → `p0_ready` pulses once, `p0_read_data` = 0xDEAD_BEEF, `mem_rd_en` is low in the DONE cycle.
- **Single write:** p1 writes 0x1234_5678 to 0x0000_0040 → `mem_address` and `mem_write_data` match, `p1_ready` pulses, `p1_read_data` unchanged.
- **Round-robin:** RR=1, both ports hold reads continuously → grant order p0, p1, p0, p1. With RR=0 → p0 every time while it keeps requesting, and `p1_stall` stays high.
- **Timeout:** TIMEOUT=8, controller never drops `mem_ready` → `p0_ready` and `p0_error` pulse together 8 cycles after ISSUE entry, read data unchanged.
- **Reset mid-access:** assert `rst` during WAIT → next cycle state is IDLE, enables 0, no ready pulse; the next request completes normally.
- **Dual enable:** p0 raises `rd_en` and `wr_en` together → write issued, `mem_rd_en` = 0.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port arbiter that sequences the SRAM controller enable/ready handshake.
// Access latency: grant edge plus controller busy time plus one DONE cycle; losers and waiters see pN_stall.
module sram_arbiter #(
  parameter bit          RR      = 1'b1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_rd_en,
  input  logic        p0_wr_en,
  input  logic [31:0] p0_address,
  input  logic [31:0] p0_write_data,
  output logic        p0_ready,
  output logic [31:0] p0_read_data,
  output logic        p0_stall,
  output logic        p0_error,
  input  logic        p1_rd_en,
  input  logic        p1_wr_en,
  input  logic [31:0] p1_address,
  input  logic [31:0] p1_write_data,
  output logic        p1_ready,
  output logic [31:0] p1_read_data,
  output logic        p1_stall,
  output logic        p1_error,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic        mem_ready,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic       req0, req1, gnt1, timeout_hit;
  logic [7:0] cnt_inc;

  assign req0        = p0_rd_en | p0_wr_en;
  assign req1        = p1_rd_en | p1_wr_en;
  // last_q resets to 1 so port 0 takes the first round-robin tie
  assign gnt1        = req1 & (~req0 | (RR & ~last_q));
  assign cnt_inc     = cnt_q + 8'd1;
  assign timeout_hit = (cnt_inc == TO_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 8'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    wr_d     = wr_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d = gnt1;
          wr_d    = gnt1 ? p1_wr_en : p0_wr_en;
          addr_d  = gnt1 ? p1_address : p0_address;
          wdata_d = gnt1 ? p1_write_data : p0_write_data;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_inc;
        if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (!mem_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // A genuine completion wins over a timeout landing on the same edge
        if (mem_ready) begin
          if (!wr_q) begin
            if (owner_q) rdata1_d = mem_read_data;
            else         rdata0_d = mem_read_data;
          end
          state_d = DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic busy;

  always_comb begin
    busy      = (state_q == ISSUE) || (state_q == WAIT);
    mem_rd_en = busy & ~wr_q;
    mem_wr_en = busy & wr_q;
    p0_ready  = (state_q == DONE) & ~owner_q;
    p1_ready  = (state_q == DONE) & owner_q;
    p0_error  = p0_ready & err_q;
    p1_error  = p1_ready & err_q;
  end

  assign p0_stall       = req0 & ~p0_ready;
  assign p1_stall       = req1 & ~p1_ready;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign p0_read_data   = rdata0_q;
  assign p1_read_data   = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: round-robin DUT drives the controller model, a fixed-priority twin shadows it.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        p0_rd_en, p0_wr_en, p1_rd_en, p1_wr_en;
  logic [31:0] p0_address, p0_write_data, p1_address, p1_write_data;
  logic        p0_ready, p0_stall, p0_error, p1_ready, p1_stall, p1_error;
  logic [31:0] p0_read_data, p1_read_data;
  logic        mem_rd_en, mem_wr_en, mem_ready;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  logic        fp_p0_ready, fp_p0_stall, fp_p0_error, fp_p1_ready, fp_p1_stall, fp_p1_error;
  logic [31:0] fp_p0_read_data, fp_p1_read_data;
  logic        fp_mem_rd_en, fp_mem_wr_en;
  logic [31:0] fp_mem_address, fp_mem_write_data;

  int checks   = 0;
  int failures = 0;

  logic        hang;
  int          busy_cfg;
  logic [31:0] rdata_cfg;
  logic        m_active, m_done;
  int          m_cnt;

  sram_arbiter #(.RR(1'b1), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .p0_rd_en(p0_rd_en), .p0_wr_en(p0_wr_en), .p0_address(p0_address), .p0_write_data(p0_write_data),
    .p0_ready(p0_ready), .p0_read_data(p0_read_data), .p0_stall(p0_stall), .p0_error(p0_error),
    .p1_rd_en(p1_rd_en), .p1_wr_en(p1_wr_en), .p1_address(p1_address), .p1_write_data(p1_write_data),
    .p1_ready(p1_ready), .p1_read_data(p1_read_data), .p1_stall(p1_stall), .p1_error(p1_error),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_ready(mem_ready), .mem_read_data(mem_read_data)
  );

  sram_arbiter #(.RR(1'b0), .TIMEOUT(8)) dut_fp (
    .clk(clk), .rst(rst),
    .p0_rd_en(p0_rd_en), .p0_wr_en(p0_wr_en), .p0_address(p0_address), .p0_write_data(p0_write_data),
    .p0_ready(fp_p0_ready), .p0_read_data(fp_p0_read_data), .p0_stall(fp_p0_stall), .p0_error(fp_p0_error),
    .p1_rd_en(p1_rd_en), .p1_wr_en(p1_wr_en), .p1_address(p1_address), .p1_write_data(p1_write_data),
    .p1_ready(fp_p1_ready), .p1_read_data(fp_p1_read_data), .p1_stall(fp_p1_stall), .p1_error(fp_p1_error),
    .mem_rd_en(fp_mem_rd_en), .mem_wr_en(fp_mem_wr_en), .mem_address(fp_mem_address),
    .mem_write_data(fp_mem_write_data), .mem_ready(mem_ready), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: drops mem_ready for busy_cfg cycles per access, then waits for the enables to fall
  initial begin
    mem_ready     = 1'b1;
    mem_read_data = 32'd0;
    m_active      = 1'b0;
    m_done        = 1'b0;
    m_cnt         = 0;
  end

  always @(negedge clk) begin
    if (rst) begin
      mem_ready = 1'b1;
      m_active  = 1'b0;
      m_done    = 1'b0;
    end else if (hang) begin
      mem_ready     = 1'b1;
      mem_read_data = 32'h0BAD_F00D;
    end else if (m_active) begin
      if (m_cnt > 1) m_cnt = m_cnt - 1;
      else begin
        mem_ready     = 1'b1;
        mem_read_data = rdata_cfg;
        m_active      = 1'b0;
        m_done        = 1'b1;
      end
    end else if (m_done) begin
      if (!(mem_rd_en || mem_wr_en)) m_done = 1'b0;
    end else if (mem_rd_en || mem_wr_en) begin
      m_active      = 1'b1;
      m_cnt         = busy_cfg;
      mem_ready     = 1'b0;
      mem_read_data = 32'hBAD0_BAD0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_rd_en, mem_wr_en, p0_ready, p1_ready, p0_error, p1_error} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {mem_rd_en, mem_wr_en, p0_ready, p1_ready, p0_error, p1_error});
    end
    checks++;
    if ({mem_address, mem_write_data} !== 64'd0) begin
      failures++;
      $display("FAIL reset_mem_bus: got addr=%h wdata=%h required 0", mem_address, mem_write_data);
    end
    checks++;
    if ({p0_read_data, p1_read_data} !== 64'd0) begin
      failures++;
      $display("FAIL reset_rdata: got p0=%h p1=%h required 0", p0_read_data, p1_read_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read;
    int nrdy = 0;
    int rdy_at = 0;
    busy_cfg  = 6;
    rdata_cfg = 32'hDEAD_BEEF;
    p0_address = 32'h0000_0100;
    p0_rd_en   = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if ({mem_rd_en, mem_wr_en, p0_stall} !== 3'b101 || mem_address !== 32'h0000_0100) begin
          failures++;
          $display("FAIL read_issue: got rd=%b wr=%b stall=%b addr=%h required 1 0 1 00000100",
                   mem_rd_en, mem_wr_en, p0_stall, mem_address);
        end
      end
      if (i == 7) begin
        checks++;
        if (p0_read_data !== 32'd0) begin
          failures++;
          $display("FAIL read_hold_pending: got %h required 00000000", p0_read_data);
        end
      end
      if (p0_ready) begin
        nrdy++;
        if (rdy_at == 0) rdy_at = i;
        checks++;
        if ({mem_rd_en, p0_error, p0_stall} !== 3'b000) begin
          failures++;
          $display("FAIL read_done_cycle: got rd=%b err=%b stall=%b required 0 0 0",
                   mem_rd_en, p0_error, p0_stall);
        end
        p0_rd_en = 1'b0;
      end
    end
    checks++;
    if (nrdy !== 1 || rdy_at !== 8) begin
      failures++;
      $display("FAIL read_ready_pulse: got count=%0d at=%0d required 1 at 8", nrdy, rdy_at);
    end
    checks++;
    if (p0_read_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL read_data: got %h required deadbeef", p0_read_data);
    end
  endtask

  task automatic test_single_write;
    int   nrdy = 0;
    int   rdy_at = 0;
    logic saw_rd = 1'b0;
    busy_cfg      = 6;
    rdata_cfg     = 32'h5A5A_5A5A;
    p1_address    = 32'h0000_0040;
    p1_write_data = 32'h1234_5678;
    p1_wr_en      = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      saw_rd = saw_rd | mem_rd_en;
      if (i == 1) begin
        checks++;
        if (mem_wr_en !== 1'b1 || mem_address !== 32'h0000_0040 || mem_write_data !== 32'h1234_5678) begin
          failures++;
          $display("FAIL write_issue: got wr=%b addr=%h wdata=%h required 1 00000040 12345678",
                   mem_wr_en, mem_address, mem_write_data);
        end
      end
      if (p1_ready) begin
        nrdy++;
        if (rdy_at == 0) rdy_at = i;
        p1_wr_en = 1'b0;
      end
    end
    checks++;
    if (nrdy !== 1 || rdy_at !== 8 || saw_rd !== 1'b0) begin
      failures++;
      $display("FAIL write_ready_pulse: got count=%0d at=%0d saw_rd=%b required 1 at 8 saw_rd 0",
               nrdy, rdy_at, saw_rd);
    end
    checks++;
    if (p1_read_data !== 32'd0 || p0_read_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL write_rdata_hold: got p1=%h p0=%h required 00000000 deadbeef",
               p1_read_data, p0_read_data);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] rr_ord = 4'b0;
    logic [3:0] fp_ord = 4'b0;
    int         rr_n = 0;
    int         fp_n = 0;
    logic       fp_stall_ok = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    busy_cfg   = 3;
    rdata_cfg  = 32'h5555_0000;
    p0_address = 32'h0000_0200;
    p1_address = 32'h0000_0300;
    p0_rd_en   = 1'b1;
    p1_rd_en   = 1'b1;
    for (int i = 1; i <= 60 && rr_n < 4; i++) begin
      @(negedge clk);
      fp_stall_ok = fp_stall_ok & fp_p1_stall;
      if (fp_p0_ready || fp_p1_ready) begin
        if (fp_n < 4) fp_ord[fp_n] = fp_p1_ready;
        fp_n++;
      end
      if (p0_ready || p1_ready) begin
        rr_ord[rr_n] = p1_ready;
        rr_n++;
      end
    end
    p0_rd_en = 1'b0;
    p1_rd_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rr_n !== 4 || rr_ord !== 4'b1010) begin
      failures++;
      $display("FAIL rr_order: got n=%0d order=%b required 4 1010 (p0,p1,p0,p1)", rr_n, rr_ord);
    end
    checks++;
    if (fp_n !== 4 || fp_ord !== 4'b0000) begin
      failures++;
      $display("FAIL fp_order: got n=%0d order=%b required 4 0000", fp_n, fp_ord);
    end
    checks++;
    if (fp_stall_ok !== 1'b1) begin
      failures++;
      $display("FAIL fp_p1_stall: got a low cycle required always high");
    end
    checks++;
    if (p1_read_data !== 32'h5555_0000 || fp_p1_read_data !== 32'd0) begin
      failures++;
      $display("FAIL rr_rdata: got rr_p1=%h fp_p1=%h required 55550000 00000000",
               p1_read_data, fp_p1_read_data);
    end
  endtask

  task automatic test_timeout;
    int   nrdy = 0;
    int   rdy_at = 0;
    logic err_ok = 1'b0;
    logic fp_err = 1'b0;
    hang       = 1'b1;
    p0_address = 32'h0000_0500;
    p0_rd_en   = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (p0_ready) begin
        nrdy++;
        if (rdy_at == 0) rdy_at = i;
        err_ok   = p0_error;
        fp_err   = fp_p0_error;
        p0_rd_en = 1'b0;
      end
    end
    hang = 1'b0;
    checks++;
    if (nrdy !== 1 || rdy_at !== 9) begin
      failures++;
      $display("FAIL timeout_ready: got count=%0d at=%0d required 1 at 9", nrdy, rdy_at);
    end
    checks++;
    if (err_ok !== 1'b1 || fp_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_error: got rr=%b fp=%b required 1 1", err_ok, fp_err);
    end
    checks++;
    if (p0_read_data !== 32'h5555_0000) begin
      failures++;
      $display("FAIL timeout_rdata: got %h required 55550000", p0_read_data);
    end
  endtask

  task automatic test_reset_mid;
    int nrdy = 0;
    int rdy_at = 0;
    busy_cfg   = 6;
    rdata_cfg  = 32'h1111_2222;
    p0_address = 32'h0000_0600;
    p0_rd_en   = 1'b1;
    repeat (3) @(negedge clk);
    rst      = 1'b1;
    p0_rd_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_rd_en, mem_wr_en, p0_ready, p0_stall} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_ctrl: got rd=%b wr=%b rdy=%b stall=%b required 0000",
               mem_rd_en, mem_wr_en, p0_ready, p0_stall);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (p0_ready) nrdy++;
    end
    checks++;
    if (nrdy !== 0 || p0_read_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_no_ready: got count=%0d rdata=%h required 0 00000000", nrdy, p0_read_data);
    end
    p0_rd_en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (p0_ready) begin
        nrdy++;
        if (rdy_at == 0) rdy_at = i;
        p0_rd_en = 1'b0;
      end
    end
    checks++;
    if (nrdy !== 1 || rdy_at !== 8 || p0_read_data !== 32'h1111_2222) begin
      failures++;
      $display("FAIL reset_mid_recover: got count=%0d at=%0d rdata=%h required 1 at 8 11112222",
               nrdy, rdy_at, p0_read_data);
    end
  endtask

  task automatic test_dual_enable;
    int nrdy = 0;
    busy_cfg      = 2;
    rdata_cfg     = 32'h9999_9999;
    p0_address    = 32'h0000_0080;
    p0_write_data = 32'hCAFE_F00D;
    p0_rd_en      = 1'b1;
    p0_wr_en      = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if ({mem_wr_en, mem_rd_en} !== 2'b10 || mem_write_data !== 32'hCAFE_F00D) begin
          failures++;
          $display("FAIL dual_issue: got wr=%b rd=%b wdata=%h required 1 0 cafef00d",
                   mem_wr_en, mem_rd_en, mem_write_data);
        end
      end
      if (p0_ready) begin
        nrdy++;
        p0_rd_en = 1'b0;
        p0_wr_en = 1'b0;
      end
    end
    checks++;
    if (nrdy !== 1 || p0_read_data !== 32'h1111_2222) begin
      failures++;
      $display("FAIL dual_complete: got count=%0d rdata=%h required 1 11112222", nrdy, p0_read_data);
    end
  endtask

  initial begin
    rst           = 1'b1;
    hang          = 1'b0;
    busy_cfg      = 6;
    rdata_cfg     = 32'd0;
    p0_rd_en      = 1'b0;
    p0_wr_en      = 1'b0;
    p1_rd_en      = 1'b0;
    p1_wr_en      = 1'b0;
    p0_address    = 32'd0;
    p0_write_data = 32'd0;
    p1_address    = 32'd0;
    p1_write_data = 32'd0;
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_dual_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
